// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment scheduler.
// Segment encoding is active-low {dp,g,f,e,d,c,b,a}; anodes are active-low.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [2:0] DIG0    = 3'b110;
  localparam logic [2:0] DIG1    = 3'b101;
  localparam logic [2:0] DIG2    = 3'b011;
  localparam logic [2:0] DIG_OFF = 3'b111;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index 0 is the rightmost entry; dp bit is always 1 (off).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [2:0] digit_anode(input logic [1:0] digit);
    case (digit)
      2'd0:    digit_anode = DIG0;
      2'd1:    digit_anode = DIG1;
      2'd2:    digit_anode = DIG2;
      default: digit_anode = DIG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_scheduler_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern (dp off).
module hex_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin owner of a 3-digit multiplexed display with blanking guard between digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 2 and 1.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV     = 32768,
  parameter int BLANK_CYCLES = 256,
  parameter int SLICE_FRAMES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [11:0] val0,
  input  logic        req1,
  input  logic [11:0] val1,
  output logic [1:0]  grant,
  output logic [2:0]  anodes,
  output logic [7:0]  cathodes,
  output logic        frame_done
);

  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int SLICE_W = $clog2(SLICE_FRAMES + 1);

  localparam logic [SLOT_W-1:0]  DRIVE_LAST = SLOT_W'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [SLICE_W-1:0] SLICE_MAX  = SLICE_W'(SLICE_FRAMES);

  state_t              r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [1:0]          r_digit;
  logic [SLICE_W-1:0]  r_slice;
  logic                r_rr;
  logic [1:0]          r_grant;
  logic [11:0]         r_snap;
  logic [2:0]          r_anodes;
  logic [7:0]          r_cathodes;
  logic                r_frame_done;

  state_t              w_state_next;
  logic [SLOT_W-1:0]   w_slot_next;
  logic [1:0]          w_digit_next;
  logic [SLICE_W-1:0]  w_slice_next;
  logic                w_rr_next;
  logic [1:0]          w_grant_next;
  logic [11:0]         w_snap_next;
  logic [2:0]          w_anodes_next;
  logic [7:0]          w_cathodes_next;
  logic                w_frame_done_next;

  logic                w_owner;
  logic                w_own_req;
  logic                w_oth_req;
  logic                w_idle_winner;
  logic [SLICE_W-1:0]  w_slice_inc;
  logic                w_switch;
  logic [3:0]          w_nibble;
  logic [7:0]          w_seg;
  logic                w_lz_blank;

  assign w_owner       = r_grant[1];
  assign w_own_req     = w_owner ? req1 : req0;
  assign w_oth_req     = w_owner ? req0 : req1;
  assign w_idle_winner = (req0 && req1) ? r_rr : req1;
  assign w_slice_inc   = (r_slice == SLICE_MAX) ? SLICE_MAX : r_slice + 1'b1;
  // Hand over when the owner's slice is used up, or immediately if the owner let go.
  assign w_switch      = w_oth_req && (!w_own_req || (w_slice_inc == SLICE_MAX));

  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    w_digit_next = r_digit;
    w_slice_next = r_slice;
    w_rr_next    = r_rr;
    w_grant_next = r_grant;
    w_snap_next  = r_snap;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_state_next = DRIVE;
          w_slot_next  = '0;
          w_digit_next = 2'd0;
          w_slice_next = '0;
          w_grant_next = w_idle_winner ? 2'b10 : 2'b01;
          w_rr_next    = ~w_idle_winner;
          w_snap_next  = w_idle_winner ? val1 : val0;
        end
      end
      DRIVE: begin
        if (r_slot == DRIVE_LAST) begin
          w_state_next = BLANK;
          w_slot_next  = '0;
        end else begin
          w_slot_next = r_slot + 1'b1;
        end
      end
      BLANK: begin
        if (r_slot != BLANK_LAST) begin
          w_slot_next = r_slot + 1'b1;
        end else if (r_digit != 2'd2) begin
          w_slot_next  = '0;
          w_digit_next = r_digit + 2'd1;
          w_state_next = DRIVE;
        end else begin
          w_slot_next  = '0;
          w_digit_next = 2'd0;
          w_state_next = DRIVE;
          w_slice_next = w_slice_inc;
          if (w_switch) begin
            w_grant_next = w_owner ? 2'b01 : 2'b10;
            w_rr_next    = w_owner;
            w_slice_next = '0;
            w_snap_next  = w_owner ? val0 : val1;
          end else if (!w_own_req) begin
            w_state_next = IDLE;
            w_grant_next = 2'b00;
            w_slice_next = '0;
          end else begin
            w_snap_next = w_owner ? val1 : val0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = 2'b00;
      end
    endcase
  end

  // Outputs are derived from the next-state values so the registered pins line up with r_state.
  always_comb begin
    case (w_digit_next)
      2'd0:    w_nibble = w_snap_next[3:0];
      2'd1:    w_nibble = w_snap_next[7:4];
      default: w_nibble = w_snap_next[11:8];
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_blank = ((w_digit_next == 2'd2) && (w_snap_next[11:8] == 4'd0)) ||
                      ((w_digit_next == 2'd1) && (w_snap_next[11:4] == 8'd0));
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_anodes_next     = DIG_OFF;
    w_cathodes_next   = SEG_BLANK;
    w_frame_done_next = 1'b0;
    if (w_state_next == DRIVE) begin
      w_anodes_next   = digit_anode(w_digit_next);
      w_cathodes_next = w_lz_blank ? SEG_BLANK : w_seg;
    end
    if ((w_state_next == BLANK) && (w_digit_next == 2'd2) && (w_slot_next == BLANK_LAST)) begin
      w_frame_done_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_slot       <= '0;
      r_digit      <= 2'd0;
      r_slice      <= '0;
      r_rr         <= 1'b0;
      r_grant      <= 2'b00;
      r_snap       <= 12'h000;
      r_anodes     <= DIG_OFF;
      r_cathodes   <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_slot       <= w_slot_next;
      r_digit      <= w_digit_next;
      r_slice      <= w_slice_next;
      r_rr         <= w_rr_next;
      r_grant      <= w_grant_next;
      r_snap       <= w_snap_next;
      r_anodes     <= w_anodes_next;
      r_cathodes   <= w_cathodes_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign grant      = r_grant;
  assign anodes     = r_anodes;
  assign cathodes   = r_cathodes;
  assign frame_done = r_frame_done;

endmodule
